// File: rtl/nav_sequencer.sv
// Jump/cruise sequencing controller driving the velocity (mode) and position (pos_mode) selects.
// Optional feature macro: NAV_ABORT_EN enables cancelling a jump with abort during CHARGE.
module nav_sequencer #(
  parameter int k               = 16,
  parameter int CHARGE_CYCLES   = 4,
  parameter int COOLDOWN_CYCLES = 8,
  parameter int CW              = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           nav_reset,
  input  logic           start,
  input  logic           stop,
  input  logic [3:0]     combat_mode,
  input  logic           jump_req,
  input  logic [3*k-1:0] jump_target,
  input  logic           abort,
  output logic [3:0]     mode,
  output logic [3:0]     pos_mode,
  output logic [3*k-1:0] jump_position,
  output logic           jump_ack,
  output logic           jump_done,
  output logic           jump_aborted,
  output logic           busy
);

  typedef enum logic [2:0] {
    ST_RESET    = 3'd0,
    ST_IDLE     = 3'd1,
    ST_CRUISE   = 3'd2,
    ST_CHARGE   = 3'd3,
    ST_JUMP     = 3'd4,
    ST_COOLDOWN = 3'd5
  } state_t;

  localparam logic [CW-1:0] CHARGE_LOAD   = CW'(CHARGE_CYCLES);
  localparam logic [CW-1:0] COOLDOWN_LOAD = CW'(COOLDOWN_CYCLES);
  localparam logic [CW-1:0] CNT_ONE       = CW'(1);
  localparam logic [CW-1:0] CNT_ZERO      = CW'(0);

  localparam logic [3:0] M_RESET   = 4'b0001;
  localparam logic [3:0] M_ATTACK  = 4'b0010;
  localparam logic [3:0] M_DEFENSE = 4'b0100;
  localparam logic [3:0] M_STEALTH = 4'b1000;

  localparam logic [3:0] P_RESET  = 4'b0001;
  localparam logic [3:0] P_NORMAL = 4'b0010;
  localparam logic [3:0] P_JUMP   = 4'b0100;
  localparam logic [3:0] P_HOLD   = 4'b1000;

  // Only the three legal combat encodings may replace the current selection.
  function automatic logic combat_valid(input logic [3:0] sel);
    combat_valid = (sel == M_ATTACK) || (sel == M_DEFENSE) || (sel == M_STEALTH);
  endfunction

  state_t           state_r, state_next_s;
  logic [CW-1:0]    cnt_r, cnt_next_s;
  logic [3:0]       combat_r, combat_next_s;
  logic [3*k-1:0]   jp_r, jp_next_s;
  logic [3:0]       mode_r, mode_next_s;
  logic [3:0]       pos_r, pos_next_s;
  logic             ack_r, ack_next_s;
  logic             done_r, done_next_s;
  logic             abt_r, abt_next_s;
  logic             busy_r, busy_next_s;

`ifndef NAV_ABORT_EN
  logic unused_abort_s;
  assign unused_abort_s = abort;
`endif

  // Next-state, counter, handshake pulses and latched target.
  always_comb begin
    state_next_s = state_r;
    cnt_next_s   = cnt_r;
    jp_next_s    = jp_r;
    ack_next_s   = 1'b0;
    done_next_s  = 1'b0;
    abt_next_s   = 1'b0;
    if (nav_reset) begin
      state_next_s = ST_RESET;
      cnt_next_s   = CNT_ZERO;
      jp_next_s    = '0;
    end else begin
      case (state_r)
        ST_RESET: begin
          state_next_s = ST_IDLE;
        end
        ST_IDLE: begin
          if (start) begin
            state_next_s = ST_CRUISE;
          end else begin
            state_next_s = ST_IDLE;
          end
        end
        ST_CRUISE: begin
          if (jump_req) begin
            state_next_s = ST_CHARGE;
            cnt_next_s   = CHARGE_LOAD;
            jp_next_s    = jump_target;
            ack_next_s   = 1'b1;
          end else if (stop) begin
            state_next_s = ST_IDLE;
          end else begin
            state_next_s = ST_CRUISE;
          end
        end
        ST_CHARGE: begin
`ifdef NAV_ABORT_EN
          if (abort) begin
            state_next_s = ST_CRUISE;
            cnt_next_s   = CNT_ZERO;
            abt_next_s   = 1'b1;
          end else if (cnt_r <= CNT_ONE) begin
`else
          if (cnt_r <= CNT_ONE) begin
`endif
            state_next_s = ST_JUMP;
            cnt_next_s   = CNT_ZERO;
          end else begin
            cnt_next_s   = cnt_r - CNT_ONE;
          end
        end
        ST_JUMP: begin
          state_next_s = ST_COOLDOWN;
          cnt_next_s   = COOLDOWN_LOAD;
          done_next_s  = 1'b1;
        end
        ST_COOLDOWN: begin
          if (cnt_r <= CNT_ONE) begin
            state_next_s = ST_CRUISE;
            cnt_next_s   = CNT_ZERO;
          end else begin
            cnt_next_s   = cnt_r - CNT_ONE;
          end
        end
        default: begin
          state_next_s = ST_RESET;
          cnt_next_s   = CNT_ZERO;
        end
      endcase
    end
  end

  // Output selects are decoded from the upcoming state so they register alongside it.
  always_comb begin
    combat_next_s = combat_r;
    mode_next_s   = M_RESET;
    pos_next_s    = P_RESET;
    busy_next_s   = 1'b0;
    if (combat_valid(combat_mode)) begin
      combat_next_s = combat_mode;
    end else begin
      combat_next_s = combat_r;
    end
    case (state_next_s)
      ST_RESET: begin
        mode_next_s = M_RESET;
        pos_next_s  = P_RESET;
      end
      ST_IDLE: begin
        mode_next_s = M_RESET;
        pos_next_s  = P_HOLD;
      end
      ST_CRUISE: begin
        mode_next_s = combat_next_s;
        pos_next_s  = P_NORMAL;
      end
      ST_CHARGE: begin
        mode_next_s = M_DEFENSE;
        pos_next_s  = P_HOLD;
        busy_next_s = 1'b1;
      end
      ST_JUMP: begin
        mode_next_s = M_RESET;
        pos_next_s  = P_JUMP;
        busy_next_s = 1'b1;
      end
      ST_COOLDOWN: begin
        mode_next_s = combat_next_s;
        pos_next_s  = P_NORMAL;
        busy_next_s = 1'b1;
      end
      default: begin
        mode_next_s = M_RESET;
        pos_next_s  = P_RESET;
      end
    endcase
  end

  // State and all registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r  <= ST_RESET;
      cnt_r    <= CNT_ZERO;
      combat_r <= M_ATTACK;
      jp_r     <= '0;
      mode_r   <= M_RESET;
      pos_r    <= P_RESET;
      ack_r    <= 1'b0;
      done_r   <= 1'b0;
      abt_r    <= 1'b0;
      busy_r   <= 1'b0;
    end else begin
      state_r  <= state_next_s;
      cnt_r    <= cnt_next_s;
      combat_r <= combat_next_s;
      jp_r     <= jp_next_s;
      mode_r   <= mode_next_s;
      pos_r    <= pos_next_s;
      ack_r    <= ack_next_s;
      done_r   <= done_next_s;
      abt_r    <= abt_next_s;
      busy_r   <= busy_next_s;
    end
  end

  assign mode          = mode_r;
  assign pos_mode      = pos_r;
  assign jump_position = jp_r;
  assign jump_ack      = ack_r;
  assign jump_done     = done_r;
  assign jump_aborted  = abt_r;
  assign busy          = busy_r;

endmodule

// File: tb/tb_nav_sequencer.sv
// Table-driven directed bench for nav_sequencer with hand-computed expected outputs.
module tb_nav_sequencer;

  localparam int K = 16;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           nav_reset, start, stop, jump_req, abort;
  logic [3:0]     combat_mode;
  logic [3*K-1:0] jump_target;
  logic [3:0]     mode, pos_mode;
  logic [3*K-1:0] jump_position;
  logic           jump_ack, jump_done, jump_aborted, busy;

  int checks = 0;
  int errors = 0;

  nav_sequencer #(.k(K), .CHARGE_CYCLES(4), .COOLDOWN_CYCLES(8), .CW(8)) dut (
    .clk(clk), .rst_n(rst_n), .nav_reset(nav_reset), .start(start), .stop(stop),
    .combat_mode(combat_mode), .jump_req(jump_req), .jump_target(jump_target), .abort(abort),
    .mode(mode), .pos_mode(pos_mode), .jump_position(jump_position),
    .jump_ack(jump_ack), .jump_done(jump_done), .jump_aborted(jump_aborted), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic           nr, st, sp;
    logic [3:0]     cm;
    logic           jr, ab;
    logic [3*K-1:0] tgt;
    logic [3:0]     e_mode, e_pos;
    logic           e_ack, e_done, e_abt, e_busy;
    logic [3*K-1:0] e_jp;
  } vec_t;

  vec_t tbl[$];

  localparam logic [3*K-1:0] T1 = {16'd100, 16'd100, 16'd100};
  localparam logic [3*K-1:0] T2 = {16'd1, 16'd2, 16'd3};
  localparam logic [3*K-1:0] T0 = 48'd0;

  task automatic chk(input string name, input logic [3*K-1:0] act, input logic [3*K-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic add(input logic nr, input logic st, input logic sp, input logic [3:0] cm,
                     input logic jr, input logic ab, input logic [3*K-1:0] tgt,
                     input logic [3:0] m, input logic [3:0] p, input logic a,
                     input logic d, input logic ba, input logic b, input logic [3*K-1:0] jp);
    vec_t v;
    v.nr = nr; v.st = st; v.sp = sp; v.cm = cm; v.jr = jr; v.ab = ab; v.tgt = tgt;
    v.e_mode = m; v.e_pos = p; v.e_ack = a; v.e_done = d; v.e_abt = ba; v.e_busy = b;
    v.e_jp = jp;
    tbl.push_back(v);
  endtask

  task automatic check_outs(input string tag, input vec_t v);
    chk({tag, ".mode"}, {44'd0, mode}, {44'd0, v.e_mode});
    chk({tag, ".pos_mode"}, {44'd0, pos_mode}, {44'd0, v.e_pos});
    chk({tag, ".jump_ack"}, {47'd0, jump_ack}, {47'd0, v.e_ack});
    chk({tag, ".jump_done"}, {47'd0, jump_done}, {47'd0, v.e_done});
    chk({tag, ".jump_aborted"}, {47'd0, jump_aborted}, {47'd0, v.e_abt});
    chk({tag, ".busy"}, {47'd0, busy}, {47'd0, v.e_busy});
    chk({tag, ".jump_position"}, jump_position, v.e_jp);
  endtask

  task automatic apply(input string tag, input vec_t v);
    @(negedge clk);
    nav_reset = v.nr; start = v.st; stop = v.sp; combat_mode = v.cm;
    jump_req = v.jr; abort = v.ab; jump_target = v.tgt;
    @(posedge clk);
    #1;
    check_outs(tag, v);
  endtask

  task automatic run_table(input string pfx);
    for (int i = 0; i < tbl.size(); i++) begin
      apply($sformatf("%s%0d", pfx, i), tbl[i]);
    end
    tbl.delete();
  endtask

  initial begin
    vec_t rv;
    rst_n = 1'b0; nav_reset = 1'b0; start = 1'b0; stop = 1'b0; combat_mode = 4'b0000;
    jump_req = 1'b0; abort = 1'b0; jump_target = T1;
    repeat (2) @(posedge clk);
    #1;
    rv.e_mode = 4'b0001; rv.e_pos = 4'b0001; rv.e_ack = 1'b0; rv.e_done = 1'b0;
    rv.e_abt = 1'b0; rv.e_busy = 1'b0; rv.e_jp = T0;
    check_outs("reset", rv);
    @(negedge clk);
    rst_n = 1'b1;

    // nr st sp cm jr ab tgt | mode pos ack done abt busy jp
    add(0,0,0,4'b0000,0,0,T1, 4'b0001,4'b1000,0,0,0,0,T0);        // IDLE
    add(0,0,0,4'b0000,0,0,T1, 4'b0001,4'b1000,0,0,0,0,T0);
    add(0,1,0,4'b1000,0,0,T1, 4'b1000,4'b0010,0,0,0,0,T0);        // CRUISE stealth
    add(0,0,0,4'b0110,0,0,T1, 4'b1000,4'b0010,0,0,0,0,T0);        // illegal mode kept
    add(0,0,0,4'b0100,0,0,T1, 4'b0100,4'b0010,0,0,0,0,T0);
    add(0,0,0,4'b0010,0,0,T1, 4'b0010,4'b0010,0,0,0,0,T0);
    add(0,0,0,4'b0000,1,0,T1, 4'b0100,4'b1000,1,0,0,1,T1);        // ack, CHARGE 1
    for (int i = 0; i < 3; i++)
      add(0,0,0,4'b0000,0,0,T1, 4'b0100,4'b1000,0,0,0,1,T1);      // CHARGE 2..4
    add(0,0,0,4'b0000,0,0,T1, 4'b0001,4'b0100,0,0,0,1,T1);        // JUMP
    add(0,0,0,4'b0000,0,0,T1, 4'b0010,4'b0010,0,1,0,1,T1);        // COOLDOWN 1, done
    add(0,0,1,4'b0000,0,0,T1, 4'b0010,4'b0010,0,0,0,1,T1);        // stop ignored
    add(0,1,0,4'b0000,0,0,T1, 4'b0010,4'b0010,0,0,0,1,T1);        // start ignored
    for (int i = 0; i < 5; i++)
      add(0,0,0,4'b0000,0,0,T1, 4'b0010,4'b0010,0,0,0,1,T1);      // COOLDOWN 4..8
    add(0,0,0,4'b0000,0,0,T1, 4'b0010,4'b0010,0,0,0,0,T1);        // CRUISE
    // jump_req held through a whole sequence
    add(0,0,0,4'b0000,1,0,T1, 4'b0100,4'b1000,1,0,0,1,T1);
    for (int i = 0; i < 3; i++)
      add(0,0,0,4'b0000,1,0,T1, 4'b0100,4'b1000,0,0,0,1,T1);
    add(0,0,0,4'b0000,1,0,T1, 4'b0001,4'b0100,0,0,0,1,T1);
    add(0,0,0,4'b0000,1,0,T1, 4'b0010,4'b0010,0,1,0,1,T1);
    for (int i = 0; i < 7; i++)
      add(0,0,0,4'b0000,1,0,T1, 4'b0010,4'b0010,0,0,0,1,T1);      // refused in COOLDOWN
    add(0,0,0,4'b0000,1,0,T1, 4'b0010,4'b0010,0,0,0,0,T1);        // CRUISE, no ack yet
    add(0,0,0,4'b0000,1,0,T1, 4'b0100,4'b1000,1,0,0,1,T1);        // ack on first CRUISE edge
    for (int i = 0; i < 3; i++)
      add(0,0,0,4'b0000,0,0,T1, 4'b0100,4'b1000,0,0,0,1,T1);
    add(0,0,0,4'b0000,0,0,T1, 4'b0001,4'b0100,0,0,0,1,T1);
    add(0,0,0,4'b0000,0,0,T1, 4'b0010,4'b0010,0,1,0,1,T1);
    add(1,0,0,4'b0000,0,0,T1, 4'b0001,4'b0001,0,0,0,0,T0);        // nav_reset in COOLDOWN
    add(0,0,0,4'b0000,0,0,T1, 4'b0001,4'b1000,0,0,0,0,T0);        // IDLE
    add(0,0,1,4'b0000,0,0,T1, 4'b0001,4'b1000,0,0,0,0,T0);        // stop in IDLE ignored
    add(0,1,0,4'b0000,0,0,T1, 4'b0010,4'b0010,0,0,0,0,T0);        // CRUISE, mode kept
    add(0,0,1,4'b0000,0,0,T1, 4'b0001,4'b1000,0,0,0,0,T0);        // stop -> IDLE
    run_table("v");

    // abort in the second CHARGE cycle
    add(0,1,0,4'b0000,0,0,T2, 4'b0010,4'b0010,0,0,0,0,T0);
    add(0,0,0,4'b0000,1,0,T2, 4'b0100,4'b1000,1,0,0,1,T2);
    add(0,0,0,4'b0000,0,0,T2, 4'b0100,4'b1000,0,0,0,1,T2);
`ifdef NAV_ABORT_EN
    add(0,0,0,4'b0000,0,1,T2, 4'b0010,4'b0010,0,0,1,0,T2);
    add(0,0,0,4'b0000,0,0,T2, 4'b0010,4'b0010,0,0,0,0,T2);
    add(0,0,0,4'b0000,1,0,T1, 4'b0100,4'b1000,1,0,0,1,T1);
`else
    add(0,0,0,4'b0000,0,1,T2, 4'b0100,4'b1000,0,0,0,1,T2);
    add(0,0,0,4'b0000,0,0,T2, 4'b0100,4'b1000,0,0,0,1,T2);
    add(0,0,0,4'b0000,0,0,T2, 4'b0001,4'b0100,0,0,0,1,T2);
    add(0,0,0,4'b0000,0,0,T2, 4'b0010,4'b0010,0,1,0,1,T2);
`endif
    run_table("abort");

    // asynchronous reset in the middle of a busy sequence
    @(negedge clk);
    jump_req = 1'b0; abort = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    rv.e_mode = 4'b0001; rv.e_pos = 4'b0001; rv.e_ack = 1'b0; rv.e_done = 1'b0;
    rv.e_abt = 1'b0; rv.e_busy = 1'b0; rv.e_jp = T0;
    check_outs("async", rv);
    @(posedge clk);
    #1;
    check_outs("async_hold", rv);
    @(negedge clk);
    rst_n = 1'b1;
    add(0,0,0,4'b0000,0,0,T1, 4'b0001,4'b1000,0,0,0,0,T0);
    add(0,1,0,4'b0000,0,0,T1, 4'b0010,4'b0010,0,0,0,0,T0);        // combat back to attack
    run_table("post");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
